// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock, on-the-fly key expansion; AES_BLOCK_COUNT_EN adds blocks_done.
module aes_encrypt_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        block_in,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        block_out,
`ifdef AES_BLOCK_COUNT_EN
    output logic                busy,
    output logic [31:0]         blocks_done
`else
    output logic                busy
`endif
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_encrypt_iter: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] blk_q, blk_d, out_q, out_d;
    logic [31:0]  win_q [NK];
    logic [31:0]  win_d [NK];
    logic [2:0]   ph_q, ph_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  nw [4];
    logic [31:0]  cw [4:NK+3];
    logic [127:0] rk, rnd_res;
    logic         accept, hit, last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k of the block sits at row k%4, column k/4 of the AES state.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   sb [16];
        logic [127:0] sh, mx;
        for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) mx[127-32*c -: 32] = mix_col(sh[127-32*c -: 32]);
        return (fin ? sh : mx) ^ k;
    endfunction

    function automatic int wrap(input int p);
        return p >= NK ? p - NK : p;
    endfunction

    assign in_ready  = !rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == ROUND;
    assign block_out = out_q;
    assign last      = rnd_q == 4'(NR);

    // Four new schedule words per cycle; the window always starts at w[4r-4], so the
    // round key is words 4..7 of {window, new words} for every key length.
    always_comb begin
        logic [31:0] prev, t;
        int          pos;
        hit  = 1'b0;
        prev = win_q[NK-1];
        for (int j = 0; j < 4; j++) begin
            pos   = wrap(int'(ph_q) + j);
            t     = (pos == 0) ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0}
                  : (NK == 8 && pos == 4) ? sub_word(prev) : prev;
            hit   = hit | (pos == 0);
            nw[j] = win_q[j] ^ t;
            prev  = nw[j];
        end
        for (int i = 4; i < NK; i++) cw[i] = win_q[i];
        for (int j = 0; j < 4; j++) cw[NK+j] = nw[j];
        rk      = {cw[4], cw[5], cw[6], cw[7]};
        rnd_res = aes_round(blk_q, rk, last);
    end

    // Next-state logic: round sequencing, key window advance and accept loading.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        out_d   = out_q;
        win_d   = win_q;
        ph_d    = ph_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE:    state_d = accept ? ROUND : IDLE;
            ROUND:   state_d = last ? DONE : ROUND;
            DONE:    state_d = out_ready ? (accept ? ROUND : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
        if (state_q == ROUND) begin
            rnd_d  = rnd_q + 4'd1;
            blk_d  = rnd_res;
            out_d  = last ? rnd_res : out_q;
            for (int i = 0; i < NK; i++) win_d[i] = cw[i+4];
            ph_d   = 3'(wrap(int'(ph_q) + 4));
            rcon_d = hit ? xtime(rcon_q) : rcon_q;
        end
        if (accept) begin
            blk_d  = block_in ^ key_in[KEY_BITS-1 -: 128];
            for (int i = 0; i < NK; i++) win_d[i] = key_in[KEY_BITS-1-32*i -: 32];
            rnd_d  = 4'd1;
            ph_d   = 3'd0;
            rcon_d = 8'h01;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            blk_q   <= '0;
            out_q   <= '0;
            ph_q    <= 3'd0;
            rcon_q  <= 8'h01;
            for (int i = 0; i < NK; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            ph_q    <= ph_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
        end
    end

`ifdef AES_BLOCK_COUNT_EN
    logic [31:0] blocks_done_q;

    // Completed-block counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) blocks_done_q <= '0;
        else if (out_valid & out_ready) blocks_done_q <= blocks_done_q + 32'd1;
    end

    assign blocks_done = blocks_done_q;
`endif
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: scoreboard bench for aes_encrypt_iter at all three key lengths; covers AES_BLOCK_COUNT_EN when defined.
module tb_aes_encrypt_iter;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst, out_ready;
    logic [2:0]   iv, ir, ov, bz;
    logic [127:0] blk_in, k128;
    logic [191:0] k192;
    logic [255:0] k256;
    logic [127:0] bo [3];
`ifdef AES_BLOCK_COUNT_EN
    logic [31:0]  bd [3];
`endif
    int           n_chk = 0, n_fail = 0, cyc = 0;
    logic [127:0] sbq [3][$];
    int           accq [3][$];
    logic [127:0] exp_v [3];
    bit           seen [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_iter #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .block_in(blk_in), .key_in(k128),
        .out_valid(ov[0]), .out_ready(out_ready), .block_out(bo[0]),
`ifdef AES_BLOCK_COUNT_EN
        .blocks_done(bd[0]),
`endif
        .busy(bz[0]));

    aes_encrypt_iter #(.KEY_BITS(192)) u_aes192 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .block_in(blk_in), .key_in(k192),
        .out_valid(ov[1]), .out_ready(out_ready), .block_out(bo[1]),
`ifdef AES_BLOCK_COUNT_EN
        .blocks_done(bd[1]),
`endif
        .busy(bz[1]));

    aes_encrypt_iter #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .block_in(blk_in), .key_in(k256),
        .out_valid(ov[2]), .out_ready(out_ready), .block_out(bo[2]),
`ifdef AES_BLOCK_COUNT_EN
        .blocks_done(bd[2]),
`endif
        .busy(bz[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accept, check latency on first out_valid, pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sbq[i].delete();
                accq[i].delete();
                seen[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (iv[i] && ir[i]) begin
                    sbq[i].push_back(exp_v[i]);
                    accq[i].push_back(cyc + 1);
                end
                if (ov[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    if (accq[i].size() == 0) check("orphan_valid", 128'(accq[i].size()), 128'h1);
                    else check($sformatf("latency_%0d", i), 128'(cyc - accq[i].pop_front()), 128'(10 + 2 * i));
                end
                if (ov[i] && out_ready) begin
                    if (sbq[i].size() == 0) check("orphan_output", 128'(sbq[i].size()), 128'h1);
                    else check($sformatf("ct_%0d", i), bo[i], sbq[i].pop_front());
                    seen[i] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int idx, input logic [255:0] key, input logic [127:0] pt,
                        input logic [127:0] ct, output int edge_no);
        int k = 0;
        blk_in     = pt;
        exp_v[idx] = ct;
        if (idx == 0) k128 = key[255:128];
        else if (idx == 1) k192 = key[255:64];
        else k256 = key;
        iv[idx] = 1'b1;
        @(negedge clk);
        while (!ir[idx] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait", 128'(ir[idx]), 128'h1);
        @(posedge clk);
        #1;
        edge_no = cyc;
        iv[idx] = 1'b0;
    endtask

    task automatic wait_ov(input int idx);
        int k = 0;
        while (!ov[idx] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_wait", 128'(ov[idx]), 128'h1);
    endtask

    task automatic drain();
        int k = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 128'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 128'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e [4];
        int t;
        rst = 1'b1; iv = 3'b000; out_ready = 1'b1; blk_in = '0;
        k128 = '0; k192 = '0; k256 = '0;
        exp_v = '{default: '0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_rst", 128'(ir), 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(ov), 128'h0);
        check("rst_block_out", bo[0], 128'h0);
        check("rst_busy", 128'(bz), 128'h0);
        check("rst_in_ready", 128'(ir), 128'h7);
`ifdef AES_BLOCK_COUNT_EN
        check("count_rst", 128'(bd[0]), 128'h0);
`endif
        send(0, {KC, 128'h0}, PTC, CTC, t);
        @(negedge clk);
        check("busy_128", 128'(bz[0]), 128'h1);
        drain();
        send(1, {K192, 64'h0}, PTC, CT192, t);
        drain();
        send(2, K256, PTC, CT256, t);
        drain();
        for (int i = 0; i < 4; i++)
            if (i % 2 == 0) send(0, {KB, 128'h0}, PTB, CTB, e[i]);
            else send(0, {KC, 128'h0}, PTC, CTC, e[i]);
        for (int i = 1; i < 4; i++) check("stream_period", 128'(e[i] - e[i-1]), 128'd11);
        drain();
        out_ready = 1'b0;
        send(0, {KC, 128'h0}, PTC, CTC, t);
        wait_ov(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_block_out", bo[0], CTC);
            check("bp_in_ready", 128'(ir[0]), 128'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0, {KB, 128'h0}, PTB, CTB, t);
        @(negedge clk);
        check("handoff_busy", 128'(bz[0]), 128'h1);
        check("handoff_out_valid", 128'(ov[0]), 128'h0);
        drain();
        send(0, {KC, 128'h0}, PTC, CTC, t);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 128'(ov[0]), 128'h0);
        check("abort_busy", 128'(bz[0]), 128'h0);
        check("abort_in_ready", 128'(ir[0]), 128'h1);
`ifdef AES_BLOCK_COUNT_EN
        check("count_after_abort", 128'(bd[0]), 128'h0);
`endif
        send(0, {KB, 128'h0}, PTB, CTB, t);
        drain();
        send(0, {KC, 128'h0}, PTC, CTC, t);
        drain();
        send(0, {KB, 128'h0}, PTB, CTB, t);
        drain();
`ifdef AES_BLOCK_COUNT_EN
        check("count_three", 128'(bd[0]), 128'h3);
        force u_aes128.blocks_done_q = 32'hFFFFFFFF;
        #1;
        release u_aes128.blocks_done_q;
`endif
        send(0, {KC, 128'h0}, PTC, CTC, t);
        drain();
`ifdef AES_BLOCK_COUNT_EN
        check("count_wrap", 128'(bd[0]), 128'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128/192/256 encryption engine that reuses the team's existing round datapath (SubByte, ShiftRows, MixColumns, AddRoundKey, plus the final round without MixColumns), one round per clock. It adds on-the-fly key expansion, a round-counter FSM and valid/ready handshakes on both sides. It replaces the fully unrolled combinational chain wherever area matters more than throughput.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256. Any other value is a elaboration-time error. Derived values:
  - Nk = KEY_BITS/32.
  - Nr = 10 / 12 / 14.
- One clock; reset is synchronous and active-high. The ports are `clk` and `rst`.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  block_in/key_in are valid.
- in_ready  out  1  engine can accept a block this cycle.
- block_in  in  128  plaintext; byte 0 is bits [127:120].
- key_in  in  KEY_BITS  cipher key; word w[0] is bits [KEY_BITS-1:KEY_BITS-32].
- out_valid  out  1  block_out holds a finished ciphertext.
- out_ready  in  1  consumer accepts block_out.
- block_out  out  128  ciphertext; same byte order as block_in.
- busy  out  1  high in ROUND state.

## Operation
- FSM states and transitions:
  - IDLE → ROUND on accept.
  - ROUND → DONE when the round counter reaches Nr.
  - DONE → IDLE on output handshake with no new input.
  - DONE → ROUND on output handshake with a simultaneous accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and is 0 while rst is high.
- Accept = in_valid & in_ready. On accept the engine:
  - loads state ← block_in ^ key_in[KEY_BITS-1:KEY_BITS-128] (round-0 AddRoundKey);
  - loads the key-expansion window with key_in;
  - sets round ← 1 and the Rcon register ← 8'h01.
- Each ROUND cycle applies the full round (sub/shift/mix/addkey) with round key r = w[4r..4r+3] for r < Nr. When r == Nr it applies the last round (no MixColumns). round then increments.
- Key expansion follows FIPS-197, four words per cycle:
  - combinational chain over a window of the last Nk words (max 256 bits);
  - i mod Nk == 0 → RotWord, then SubWord, then ^ Rcon;
  - Nk==8 and i mod 8 == 4 → SubWord only;
  - Rcon advances by xtime (0x80 → 0x1b) each time it is consumed.
- For Nk=6/8, words already present in key_in are used before any generated words. Round keys therefore straddle window loads; the expansion must stay in lockstep with round.
- The final round result is written to block_out and out_valid is set in the same edge. Both hold stable until out_ready.
- Inputs are ignored while in_ready is low. key_in is sampled only at accept; there is no key persistence between blocks.

## Timing
- Reset values: state IDLE, out_valid 0, block_out 128'h0, busy 0. in_ready is 1 in the first cycle after rst deasserts.
- Latency: accept at edge E0, rounds at E1..ENr. out_valid is high from ENr onward, i.e. Nr cycles after accept (10/12/14).
- Throughput: one block per Nr+1 cycles, achieved when out_ready is held high and in_valid is presented in DONE. The output handshake and the next accept share one edge.
- Back-pressure: with out_ready low, DONE is held indefinitely. block_out is unchanged and in_ready is 0.
- rst in any state aborts immediately. Round state is discarded and out_valid clears on that edge.
- busy is 1 exactly during the Nr ROUND cycles.

## Configuration
- AES_BLOCK_COUNT_EN defined: adds output port blocks_done (out, 32 bits). It resets to 0 and increments by 1 on each output handshake, wrapping 32'hFFFFFFFF → 0.
- AES_BLOCK_COUNT_EN undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- KEY_BITS=192, key 000102…1617, same pt → dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles. KEY_BITS=256, key 000102…1e1f → 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Streaming, KEY_BITS=128, out_ready=1, in_valid=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32, alternating with the Appendix C vector. Outputs appear every 11 cycles with no gaps.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid. block_out stays stable and in_ready stays 0. Raise out_ready with in_valid=1: one-edge handoff, and busy goes high the next cycle.
- Assert rst at round 5. Next cycle: out_valid=0, busy=0, in_ready=1. A new block then completes correctly with no residue from the aborted run.
- With AES_BLOCK_COUNT_EN: blocks_done=0 after reset and 3 after three handshakes. Preloading the counter by force to 32'hFFFFFFFF gives 0 after the next handshake.
